// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH payload/valid pipeline registers with per-stage flush,
// back-propagating stall, optional bubble collapsing and saturating event counters.
module pipe_stage_chain #(
    parameter int                DATA_W        = 96,
    parameter int                DEPTH         = 2,
    parameter int                BUBBLE_SQUASH = 1,
    parameter logic [DATA_W-1:0] FLUSH_VAL     = '0,
    parameter int                CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              stall,
    input  logic [DEPTH-1:0]  flush,
    input  logic              cnt_clr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic SQUASH = (BUBBLE_SQUASH != 0);

    logic [DEPTH-1:0]  v_q, v_d;
    logic [DATA_W-1:0] d_q [DEPTH];
    logic [DATA_W-1:0] d_d [DEPTH];

    logic [DEPTH-1:0]  adv;
    logic [DEPTH-1:0]  src_v;
    logic [DATA_W-1:0] src_d [DEPTH];
    logic [DEPTH-1:0]  disc;

    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              stall_ev, flush_ev;

    // A stage advances when the stage after it advances, or when it is empty
    // and bubbles may be collapsed; the output stage advances on !stall.
    always_comb begin : advance_logic
        logic run;
        run = !stall;
        adv = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            run    = run || (SQUASH && !v_q[i]);
            adv[i] = run;
        end
    end

    always_comb begin : source_select
        src_v    = '0;
        src_v[0] = in_valid;
        src_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = v_q[i-1];
            src_d[i] = d_q[i-1];
        end
    end

    // NOTE: every variable gets its hold value first, so no path through the
    // block leaves it unassigned and no latch is inferred.
    always_comb begin : next_state
        v_d  = v_q;
        d_d  = d_q;
        disc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush[i]) begin
                v_d[i]  = 1'b0;
                d_d[i]  = FLUSH_VAL;
                disc[i] = adv[i] ? src_v[i] : v_q[i];
            end else if (adv[i]) begin
                v_d[i] = src_v[i];
                d_d[i] = src_v[i] ? src_d[i] : FLUSH_VAL;
            end
        end
    end

    assign stall_ev = stall && v_q[DEPTH-1] && !flush[DEPTH-1];
    assign flush_ev = |disc;

    always_comb begin : counter_next
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_ev && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush_ev && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: the payload registers are reset too, because out_data must read
    // FLUSH_VAL while in reset; a plain data path could skip this reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q         <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= FLUSH_VAL;
        end else begin
            // NOTE: non-blocking updates let every stage sample the pre-edge
            // state of its neighbour, which is what makes this a shift chain.
            v_q         <= v_d;
            d_q         <= d_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
